// File: rtl/bg_pattern_gen.sv
// bg_pattern_gen
// Background pattern generator for the VGA path. It brings the SPI control
// words into the pixel clock domain and commits them only on frame_tick, so
// a change never tears mid-frame. It then renders one registered 6-bit
// colour per pixel. The patterns are solid, scrolling vertical or horizontal
// bars, a scrolling checker, and an animated gradient.
//
// Ports
//   clk              pixel clock, rising edge
//   rst_n            asynchronous active-low reset
//   background_state mode[2:0] / speed[4:3] / reserved[7:5], SCLK domain
//   solid_color      {R[1:0],G[1:0],B[1:0]} base colour, SCLK domain
//   hpos, vpos       current pixel column / row
//   display_on       high during active video
//   frame_tick       one-cycle pulse at start of vertical blank
//   rgb              registered pixel colour, one cycle after hpos/vpos
//   frame_cnt        free-running frame counter

module bg_pattern_gen #(
    parameter int H_BITS = 10,
    parameter int V_BITS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        background_state,
    input  logic [5:0]        solid_color,
    input  logic [H_BITS-1:0] hpos,
    input  logic [V_BITS-1:0] vpos,
    input  logic              display_on,
    input  logic              frame_tick,
    output logic [5:0]        rgb,
    output logic [7:0]        frame_cnt
);

    localparam logic [2:0] MODE_SOLID    = 3'd0;
    localparam logic [2:0] MODE_VBARS    = 3'd1;
    localparam logic [2:0] MODE_HBARS    = 3'd2;
    localparam logic [2:0] MODE_CHECKER  = 3'd3;
    localparam logic [2:0] MODE_GRADIENT = 3'd4;

    // Two-flop synchronizers. Multi-bit skew is harmless because the values
    // are quasi-static and only sampled at frame_tick.
    logic [7:0] bs_meta_q, bs_meta_d, bs_s_q, bs_s_d;
    logic [5:0] sc_meta_q, sc_meta_d, sc_s_q, sc_s_d;

    logic [7:0] act_state_q, act_state_d;
    logic [5:0] act_color_q, act_color_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [5:0] rgb_q, rgb_d;

    logic [2:0] mode;
    logic [1:0] speed;
    logic [9:0] off;
    logic [9:0] hs;
    logic [9:0] vs;
    logic [5:0] grad;

    function automatic logic [5:0] pal(input logic [2:0] i);
        return {i[2], i[2], i[1], i[1], i[0], i[0]};
    endfunction

    always_comb begin
        bs_meta_d   = background_state;
        bs_s_d      = bs_meta_q;
        sc_meta_d   = solid_color;
        sc_s_d      = sc_meta_q;

        act_state_d = act_state_q;
        act_color_d = act_color_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            act_state_d = bs_s_q;
            act_color_d = sc_s_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        // Pixel path uses the pre-tick config and counter, so a frame_tick
        // cycle still renders with the old settings.
        mode  = act_state_q[2:0];
        speed = act_state_q[4:3];
        off   = 10'({2'b00, frame_cnt_q} << speed);
        hs    = hpos[9:0] + off;
        vs    = vpos[9:0] + off;
        grad  = hpos[9:4] + frame_cnt_q[5:0];

        rgb_d = act_color_q;
        case (mode)
            MODE_SOLID:    rgb_d = act_color_q;
            MODE_VBARS:    rgb_d = pal(hs[7:5]);
            MODE_HBARS:    rgb_d = pal(vs[7:5]);
            // Checker scrolls horizontally only; rows use the raw vpos.
            MODE_CHECKER:  rgb_d = (hs[5] ^ vpos[5]) ? act_color_q : ~act_color_q;
            MODE_GRADIENT: rgb_d = grad;
            default:       rgb_d = act_color_q;
        endcase
        if (!display_on) begin
            rgb_d = 6'b000000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_meta_q   <= '0;
            bs_s_q      <= '0;
            sc_meta_q   <= '0;
            sc_s_q      <= '0;
            act_state_q <= '0;
            act_color_q <= '0;
            frame_cnt_q <= '0;
            rgb_q       <= '0;
        end else begin
            bs_meta_q   <= bs_meta_d;
            bs_s_q      <= bs_s_d;
            sc_meta_q   <= sc_meta_d;
            sc_s_q      <= sc_s_d;
            act_state_q <= act_state_d;
            act_color_q <= act_color_d;
            frame_cnt_q <= frame_cnt_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rgb       = rgb_q;
    assign frame_cnt = frame_cnt_q;

    // Reserved config bits and the scroll-sum bits no pattern looks at.
    logic unused_bits;
    assign unused_bits = ^{act_state_q[7:5], hs[9:8], hs[4:0], vs[9:8], vs[4:0]};

endmodule
